mod_n_down_counter: RTL and testbench
=====================================

MOD_N_DOWN_COUNTER -- requirements
Module: mod_n_down_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, the bit width of count, load_data and modulus.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port load  input  1  synchronous parallel load strobe.
REQ-005 SHALL provide port load_data  input  WIDTH  value loaded into count.
REQ-006 SHALL provide port modulus  input  WIDTH  count range N; 0 means 2^WIDTH.
REQ-007 SHALL provide port start  input  1  request to enter RUN from IDLE.
REQ-008 SHALL provide port stop  input  1  request to return to IDLE.
REQ-009 SHALL provide port enable  input  1  count qualifier in RUN.
REQ-010 SHALL provide port oneshot  input  1  1 = stop at zero, 0 = wrap to N-1.
REQ-011 SHALL provide port count  output  WIDTH  current registered count.
REQ-012 SHALL provide port busy  output  1  high while state is RUN.
REQ-013 SHALL provide port tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 SHALL provide port done  output  1  registered one-cycle pulse on oneshot completion.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN; all outputs registered; busy = (state == RUN).
REQ-016 SHALL define Nm1 = modulus - 1 in WIDTH-bit arithmetic (modulus 0 gives Nm1 = all ones).
REQ-017 SHALL, on load, set count <= min(load_data, Nm1) next edge, in either state, with no decrement that cycle.
REQ-018 SHALL, in IDLE, hold count unless load; transition to RUN on start when stop is low.
REQ-019 SHALL, in IDLE with start and stop both high, remain in IDLE (stop has priority).
REQ-020 SHALL, in RUN with stop high, go to IDLE next edge, hold count, and assert neither tc nor done.
REQ-021 SHALL, in RUN with enable high, no load, no stop and count != 0, decrement count by 1.
REQ-022 SHALL, in RUN with enable high, no load, no stop, count == 0 and oneshot low, set count <= Nm1, stay in RUN, and assert tc the next cycle.
REQ-023 SHALL, in RUN with enable high, no load, no stop, count == 0 and oneshot high, hold count at 0, go to IDLE, and assert tc and done the next cycle.
REQ-024 SHALL, in RUN with enable low, hold count and state.
REQ-025 SHALL give load priority over a terminal event: load in the zero-count cycle suppresses tc/done and wrap.
REQ-026 SHALL allow load and start together in IDLE: count takes loaded value and state becomes RUN at the same edge.
REQ-027 SHALL hold tc and done high for exactly one cycle per terminal event; consecutive wraps (modulus 1) give tc every enabled cycle.
REQ-028 SHALL sample modulus every cycle; a change takes effect at the next wrap or load, with count not corrected in place.

Reset
REQ-029 SHALL, while reset is high, asynchronously force state = IDLE, count = 0, busy = 0, tc = 0, done = 0.
REQ-030 SHALL, on reset assertion mid-RUN, abandon the run with no tc or done; the first edge after deassertion is evaluated from IDLE.

Verification
REQ-031 SHALL cover: modulus 5, load_data 2, load+start, enable held high -> count 2,1,0,4,3; tc high only in the cycle after the 0->4 transition.
REQ-032 SHALL cover: oneshot 1, modulus 10, load 3, start, enable high -> count 3,2,1,0, held at 0; tc=done=1 for one cycle; busy falls with the IDLE transition.
REQ-033 SHALL cover: modulus 6, load_data 9 -> count 5 (clamped); modulus 0 with WIDTH 4, count 0 wraps to 15.
REQ-034 SHALL cover: RUN at count 0 with enable, load 7 same cycle -> count 7, no tc; stop and start together in IDLE -> remains IDLE.
REQ-035 SHALL cover: enable toggled 1,0,1 from count 4 -> 3,3,2; reset pulsed mid-RUN at count 2 -> count 0, busy 0, no tc/done.

Source files
------------

// File: rtl/mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// mod_n_down_counter
//
// Programmable modulo-N down counter with an IDLE/RUN control FSM.
// The count runs from a loaded value down to 0. At 0 it either wraps to N-1
// (continuous mode) or stops and returns to IDLE (oneshot mode).
// Every output comes straight from a register.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous, active-high reset
//   load       in   synchronous parallel load strobe (works in IDLE and RUN)
//   load_data  in   [WIDTH]  value to load; clamped to N-1
//   modulus    in   [WIDTH]  count range N; 0 selects 2^WIDTH
//   start      in   leave IDLE and enter RUN (ignored while stop is high)
//   stop       in   return to IDLE; takes priority over start and counting
//   enable     in   count qualifier while in RUN
//   oneshot    in   1 = stop at zero, 0 = wrap to N-1
//   count      out  [WIDTH]  current count
//   busy       out  high while the FSM is in RUN
//   tc         out  one-cycle terminal-count pulse
//   done       out  one-cycle pulse when a oneshot run completes
//   state_dbg  out  FSM state (0 = IDLE, 1 = RUN), for observation only
//
// Control is level-sensitive and sampled at each rising edge. There is no
// valid/ready handshake: a strobe acts on every edge at which it is high.
// -----------------------------------------------------------------------------
module mod_n_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] modulus,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             done_next;

    logic [WIDTH-1:0] nm1;
    logic [WIDTH-1:0] load_val;
    logic             count_step;
    logic             terminal;

    // modulus 0 wraps to all ones here, so it selects the full 2^WIDTH range.
    assign nm1      = modulus - ONE;
    assign load_val = (load_data > nm1) ? nm1 : load_data;

    // A counting step happens only in RUN, with enable high and no stop.
    // A load in the same cycle replaces the step, so it also masks the
    // terminal event at zero.
    assign count_step = (state == RUN) && !stop && enable;
    assign terminal   = count_step && !load && (count == '0);

    always_comb begin
        state_next = state;
        count_next = count;
        tc_next    = 1'b0;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (terminal && oneshot) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            count_next = load_val;
        end else if (terminal) begin
            // Oneshot mode parks at zero. Continuous mode reloads N-1 using
            // the modulus sampled now, which is where a changed modulus first
            // takes effect.
            count_next = oneshot ? '0 : nm1;
            tc_next    = 1'b1;
            done_next  = oneshot;
        end else if (count_step) begin
            count_next = count - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next == RUN);
            tc    <= tc_next;
            done  <= done_next;
        end
    end

    assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_mod_n_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_n_down_counter
//
// Self-checking bench for mod_n_down_counter (WIDTH = 4).
// A reference model computes the expected outputs using integer arithmetic
// on N, where N = modulus, or 2^WIDTH when modulus is 0.
// Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_mod_n_down_counter;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load;
  logic [W-1:0] load_data;
  logic [W-1:0] modulus;
  logic         start;
  logic         stop;
  logic         enable;
  logic         oneshot;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;
  logic         state_dbg;

  mod_n_down_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .modulus   (modulus),
    .start     (start),
    .stop      (stop),
    .enable    (enable),
    .oneshot   (oneshot),
    .count     (count),
    .busy      (busy),
    .tc        (tc),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {run, tc, done, count}.
  logic [W+2:0] exp_q[$];

  // Reference model state.
  int m_count;
  bit m_run;
  bit m_tc;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run   = 1'b0;
    m_count = 0;
    m_tc    = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_push();
    logic [W-1:0] c;
    c = m_count[W-1:0];
    exp_q.push_back({m_run, m_tc, m_done, c});
  endfunction

  // One rising edge of the reference behaviour, using the inputs present
  // at that edge.
  function automatic void model_edge();
    int  n;
    int  top;
    int  ld;
    bit  counting;
    bit  fire;
    if (reset) begin
      model_reset();
    end else begin
      n        = (modulus == 0) ? (1 << W) : int'(modulus);
      top      = n - 1;
      ld       = (int'(load_data) < top) ? int'(load_data) : top;
      counting = m_run && !stop && enable;
      fire     = counting && !load && (m_count == 0);
      m_tc     = fire;
      m_done   = fire && oneshot;
      if (load)
        m_count = ld;
      else if (fire)
        m_count = oneshot ? 0 : top;
      else if (counting)
        m_count = m_count - 1;
      if (!m_run)
        m_run = start && !stop;
      else if (stop || (fire && oneshot))
        m_run = 1'b0;
    end
    model_push();
  endfunction

  task automatic compare_outputs();
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("count", 32'(count), 32'(e[W-1:0]));
      check("done",  32'(done),  32'(e[W]));
      check("tc",    32'(tc),    32'(e[W+1]));
      check("busy",  32'(busy),  32'(e[W+2]));
      check("state", 32'(state_dbg), 32'(e[W+2]));
    end
  endtask

  // ---------------- driver ----------------
  // Advances one clock edge with the current inputs, then checks the outputs
  // just after the edge. The caller may change inputs as soon as this returns.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic set_ctl(input logic ld, input logic st, input logic sp, input logic en);
    load   = ld;
    start  = st;
    stop   = sp;
    enable = en;
  endtask

  // Directed expectations, written out as constants.
  int s1_cnt[4]  = '{1, 0, 4, 3};
  int s1_tc[4]   = '{0, 0, 1, 0};
  int s2_cnt[5]  = '{2, 1, 0, 0, 0};
  int s2_tc[5]   = '{0, 0, 0, 1, 0};
  int s2_busy[5] = '{1, 1, 1, 0, 0};

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    load_data = '0;
    modulus   = 4'd5;
    start     = 1'b0;
    stop      = 1'b0;
    enable    = 1'b0;
    oneshot   = 1'b0;
    model_reset();

    // Reset state.
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    cycle();
    reset = 1'b0;

    // Scenario 1: modulus 5, load 2 together with start, continuous count.
    modulus   = 4'd5;
    load_data = 4'd2;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check("s1_load", 32'(count), 32'd2);
    check("s1_busy", 32'(busy),  32'd1);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("s1_seq_count", 32'(count), 32'(s1_cnt[i]));
      check("s1_seq_tc",    32'(tc),    32'(s1_tc[i]));
    end

    // Scenario 2: oneshot, modulus 10, load 3.
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("s2_stop_busy", 32'(busy), 32'd0);
    modulus   = 4'd10;
    oneshot   = 1'b1;
    load_data = 4'd3;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("s2_load", 32'(count), 32'd3);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s2_seq_count", 32'(count), 32'(s2_cnt[i]));
      check("s2_seq_tc",    32'(tc),    32'(s2_tc[i]));
      check("s2_seq_done",  32'(done),  32'(s2_tc[i]));
      check("s2_seq_busy",  32'(busy),  32'(s2_busy[i]));
    end

    // Scenario 3: clamp on load, then modulus 0 wraps through 2^W - 1.
    oneshot   = 1'b0;
    modulus   = 4'd6;
    load_data = 4'd9;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    check("s3_clamp", 32'(count), 32'd5);
    check("s3_idle",  32'(busy),  32'd0);
    modulus   = 4'd0;
    load_data = 4'd0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("s3_wrap15", 32'(count), 32'd15);
    check("s3_wrap_tc", 32'(tc),   32'd1);

    // Scenario 4: load wins over the terminal event; stop beats start.
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    modulus   = 4'd10;
    load_data = 4'd0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("s4_at_zero", 32'(count), 32'd0);
    load_data = 4'd7;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("s4_load7", 32'(count), 32'd7);
    check("s4_no_tc", 32'(tc),    32'd0);
    check("s4_run",   32'(busy),  32'd1);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    check("s4_stop_hold", 32'(count), 32'd7);
    set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    check("s4_stop_start", 32'(busy), 32'd0);

    // Scenario 5: enable gating, then asynchronous reset mid-run.
    load_data = 4'd4;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("s5_en1", 32'(count), 32'd3);
    enable = 1'b0;
    cycle();
    check("s5_en0", 32'(count), 32'd3);
    enable = 1'b1;
    cycle();
    check("s5_en1b", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    model_reset();
    model_push();
    compare_outputs();
    check("s5_async_count", 32'(count), 32'd0);
    cycle();
    reset = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("s5_post_busy", 32'(busy), 32'd0);

    // Randomized run.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      load      = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 11) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      oneshot   = ($urandom_range(0, 3) == 0);
      load_data = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 15) == 0)
        modulus = W'($urandom_range(0, 2));
      else if ($urandom_range(0, 15) == 0)
        modulus = W'($urandom_range(0, (1 << W) - 1));
      cycle();
    end
    reset = 1'b0;

    // Report.
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
